fcbrwf: RTL
===========

// Module: fcbrwf
// PURPOSE
//  FCB read/write FIFO stage; sits directly downstream of the FCB APB slave and the SPI slave interface.
//  Muxes the active host source into a 40-bit Write FIFO (WFF) that the SFR/cfg engine drains.
//  Returns engine read data to the host through a 32-bit Cfg Read FIFO (CRF).
//  Both FIFOs are first-word-fall-through: head data is valid while not empty.
// PARAMETERS
//  PAR_WFF_DEPTH  8   WFF entries; power of two, >=4
//  PAR_CRF_DEPTH  8   CRF entries; power of two, >=4
// PORTS
//  fcb_sys_clk               in   1   main FCB clock
//  fcb_sys_rst_n             in   1   async active-low reset
//  faps_frwf_apb_on          in   1   1: APB is host source, 0: SPI is host source
//  faps_frwf_wff_wr_en       in   1   APB WFF push
//  faps_frwf_wff_wr_data     in   40  APB entry: [39] wr(1)/rd(0), [38:32] addr, [31:0] data
//  faps_frwf_crf_rd_en       in   1   APB CRF pop
//  fssi_frwf_wff_wr_en       in   1   SPI WFF push
//  fssi_frwf_wff_wr_data     in   40  SPI entry, same format
//  fssi_frwf_crf_rd_en       in   1   SPI CRF pop
//  frwf_wff_full             out  1   WFF count == DEPTH
//  frwf_wff_full_m1          out  1   WFF count >= DEPTH-1
//  frwf_crf_empty            out  1   CRF count == 0
//  frwf_crf_empty_p1         out  1   CRF count <= 1
//  frwf_crf_rd_data          out  32  CRF head; holds last head value when empty
//  frwf_fsfr_wff_empty       out  1   WFF empty, engine side
//  frwf_fsfr_wff_rd_data     out  40  WFF head
//  fsfr_frwf_wff_rd_en       in   1   engine WFF pop
//  fsfr_frwf_crf_wr_en       in   1   engine CRF push
//  fsfr_frwf_crf_wr_data     in   32  engine CRF data
//  frwf_fsfr_crf_full        out  1   CRF full, engine side
//  frwf_err_ovf              out  1   sticky: push attempted while full (either FIFO)
//  frwf_err_udf              out  1   sticky: pop attempted while empty (either FIFO)
//  frwf_err_clr              in   1   synchronous clear of both sticky flags
// BEHAVIOUR
//  Reset: all pointers and counts 0; empty=empty_p1=1; full=full_m1=0; crf_rd_data=0; wff_rd_data=0; errors 0.
//  Source mux: apb_on=1 selects faps_* push/pop; apb_on=0 selects fssi_*; the unselected source is ignored.
//  Push is accepted iff wr_en && !full; data is visible at the head (if FIFO was empty) the next cycle.
//  Pop is accepted iff rd_en && !empty; the head advances the next cycle; rd_data shows the current head combinationally.
//  Latency: push-to-engine-visible is 1 cycle; engine CRF push to host-visible is 1 cycle.
//  Simultaneous push+pop on the same FIFO: both accepted when !full && !empty; count unchanged.
//  Push when full: the entry is dropped, pointers are unchanged, and err_ovf is set.
//  Push+pop while full: the pop is accepted and the push is dropped; flags are evaluated on current-cycle state.
//  Pop when empty: ignored, err_udf set, rd_data holds.
//  Counts are $clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH with no special case at wrap.
//  All flags are registered, derived from the next-cycle count, and valid the cycle after the push/pop.
//  Source switch: any edge of faps_frwf_apb_on flushes both FIFOs on the following clock.
//    Flush resets pointers and counts, leaves errors unchanged, and ignores pushes/pops in the flush cycle.
//    Purpose: abandon in-flight transactions of the old host.
//    apb_on is registered once for edge detection; the mux uses the live value.
//  err_clr and a new error in the same cycle: the error wins (the flag stays set).
//  Reset asserted mid-transfer: immediate async clear; entries are lost; no partial state is retained.
// STRUCTURE
//  fcb_pkg: FCB_CFGDP_ADDR=7'h20, typedef struct packed {logic wr; logic [6:0] addr; logic [31:0] data;} fcb_wff_entry_t.
//  Sub-module fcb_sync_fifo #(WIDTH,DEPTH), instantiated twice (WFF 40b, CRF 32b).
//    Ports: push, pop, flush, data, head, full, full_m1, empty, empty_p1, ovf, udf.
//  Top level: source mux, apb_on edge detect, sticky error logic.
// TESTING
//  1 Reset then idle, 10 cycles -> empty=1, empty_p1=1, full=0, crf_rd_data=0, no errors.
//  2 apb_on=1, push 8 APB entries {1,7'h20,i}; push 9th -> full_m1 after the 7th and full after the 8th.
//    9th push dropped, err_ovf=1; engine pops 8 -> heads 0..7 in order, then empty.
//  3 Engine pushes 32'hA5A5_0001; APB pops next cycle -> rd_data=A5A5_0001 in the pop cycle.
//    empty_p1 is 1 throughout; an extra pop sets err_udf=1.
//  4 WFF at count 3: simultaneous APB push and engine pop for 20 cycles -> count stays 3, heads strictly ordered across wrap.
//  5 apb_on=1 with 4 entries queued; drop apb_on to 0 -> both FIFOs empty 2 cycles later; fssi push is then accepted and faps push ignored.
//  6 Async reset mid-burst with WFF count 5 -> flags return to reset values immediately; err_clr with a coincident ovf -> err_ovf stays 1.

Source files
------------

// File: rtl/fcb_pkg.sv
// Shared FCB types and constants for the read/write FIFO stage.
// A WFF entry is a host request: write/read flag, register address and data.
package fcb_pkg;

  localparam logic [6:0] FCB_CFGDP_ADDR = 7'h20;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } fcb_wff_entry_t;

endpackage

// File: rtl/fcb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered flags, flush and error pulses.
// When empty, the head output holds the value of the last entry popped.
module fcb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             fcb_sys_clk,
  input  logic             fcb_sys_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             full_m1,
  output logic             empty,
  output logic             empty_p1,
  output logic             ovf,
  output logic             udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic             full_m1_q, full_m1_d;
  logic             empty_q, empty_d;
  logic             empty_p1_q, empty_p1_d;
  logic             push_ok, pop_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    push_ok    = push && !full_q && !flush;
    pop_ok     = pop && !empty_q && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        hold_d   = mem_q[rd_ptr_q];
      end
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
    full_d     = (cnt_d == CW'(DEPTH));
    full_m1_d  = (cnt_d >= CW'(DEPTH - 1));
    empty_d    = (cnt_d == '0);
    empty_p1_d = (cnt_d <= CW'(1));
  end

  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!fcb_sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      full_m1_q  <= 1'b0;
      empty_q    <= 1'b1;
      empty_p1_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      full_m1_q  <= full_m1_d;
      empty_q    <= empty_d;
      empty_p1_q <= empty_p1_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head mux masks stale entries while empty.
  always_ff @(posedge fcb_sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data;
  end

  assign head     = empty_q ? hold_q : mem_q[rd_ptr_q];
  assign full     = full_q;
  assign full_m1  = full_m1_q;
  assign empty    = empty_q;
  assign empty_p1 = empty_p1_q;
  assign ovf      = push && full_q && !flush;
  assign udf      = pop && empty_q && !flush;

endmodule

// File: rtl/fcbrwf.sv
// FCB read/write FIFO stage: muxes APB/SPI host traffic into the WFF and returns engine
// read data through the CRF; a host switch flushes both FIFOs, errors are sticky.
module fcbrwf
  import fcb_pkg::*;
#(
  parameter int PAR_WFF_DEPTH = 8,
  parameter int PAR_CRF_DEPTH = 8
) (
  input  logic        fcb_sys_clk,
  input  logic        fcb_sys_rst_n,
  input  logic        faps_frwf_apb_on,
  input  logic        faps_frwf_wff_wr_en,
  input  logic [39:0] faps_frwf_wff_wr_data,
  input  logic        faps_frwf_crf_rd_en,
  input  logic        fssi_frwf_wff_wr_en,
  input  logic [39:0] fssi_frwf_wff_wr_data,
  input  logic        fssi_frwf_crf_rd_en,
  output logic        frwf_wff_full,
  output logic        frwf_wff_full_m1,
  output logic        frwf_crf_empty,
  output logic        frwf_crf_empty_p1,
  output logic [31:0] frwf_crf_rd_data,
  output logic        frwf_fsfr_wff_empty,
  output logic [39:0] frwf_fsfr_wff_rd_data,
  input  logic        fsfr_frwf_wff_rd_en,
  input  logic        fsfr_frwf_crf_wr_en,
  input  logic [31:0] fsfr_frwf_crf_wr_data,
  output logic        frwf_fsfr_crf_full,
  output logic        frwf_err_ovf,
  output logic        frwf_err_udf,
  input  logic        frwf_err_clr
);

  fcb_wff_entry_t wff_in;
  fcb_wff_entry_t wff_head;
  logic           wff_push, crf_pop, flush;
  logic           wff_ovf, wff_udf, crf_ovf, crf_udf;
  logic           unused_wff_empty_p1, unused_crf_full_m1;
  logic           apb_on_q, apb_on_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_udf_q, err_udf_d;

  // The mux follows the live select; only edge detection uses the registered copy.
  assign wff_in   = faps_frwf_apb_on ? faps_frwf_wff_wr_data : fssi_frwf_wff_wr_data;
  assign wff_push = faps_frwf_apb_on ? faps_frwf_wff_wr_en : fssi_frwf_wff_wr_en;
  assign crf_pop  = faps_frwf_apb_on ? faps_frwf_crf_rd_en : fssi_frwf_crf_rd_en;
  assign flush    = faps_frwf_apb_on ^ apb_on_q;

  always_comb begin
    apb_on_d  = faps_frwf_apb_on;
    err_ovf_d = frwf_err_clr ? 1'b0 : err_ovf_q;
    err_udf_d = frwf_err_clr ? 1'b0 : err_udf_q;
    if (wff_ovf || crf_ovf) err_ovf_d = 1'b1;
    if (wff_udf || crf_udf) err_udf_d = 1'b1;
  end

  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n) begin
      apb_on_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      apb_on_q  <= apb_on_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  fcb_sync_fifo #(
    .WIDTH ($bits(fcb_wff_entry_t)),
    .DEPTH (PAR_WFF_DEPTH)
  ) u_wff (
    .fcb_sys_clk   (fcb_sys_clk),
    .fcb_sys_rst_n (fcb_sys_rst_n),
    .push          (wff_push),
    .pop           (fsfr_frwf_wff_rd_en),
    .flush         (flush),
    .data          (wff_in),
    .head          (wff_head),
    .full          (frwf_wff_full),
    .full_m1       (frwf_wff_full_m1),
    .empty         (frwf_fsfr_wff_empty),
    .empty_p1      (unused_wff_empty_p1),
    .ovf           (wff_ovf),
    .udf           (wff_udf)
  );

  fcb_sync_fifo #(
    .WIDTH (32),
    .DEPTH (PAR_CRF_DEPTH)
  ) u_crf (
    .fcb_sys_clk   (fcb_sys_clk),
    .fcb_sys_rst_n (fcb_sys_rst_n),
    .push          (fsfr_frwf_crf_wr_en),
    .pop           (crf_pop),
    .flush         (flush),
    .data          (fsfr_frwf_crf_wr_data),
    .head          (frwf_crf_rd_data),
    .full          (frwf_fsfr_crf_full),
    .full_m1       (unused_crf_full_m1),
    .empty         (frwf_crf_empty),
    .empty_p1      (frwf_crf_empty_p1),
    .ovf           (crf_ovf),
    .udf           (crf_udf)
  );

  assign frwf_fsfr_wff_rd_data = wff_head;
  assign frwf_err_ovf          = err_ovf_q;
  assign frwf_err_udf          = err_udf_q;

endmodule
